// File: rtl/regfile_pkg.sv
// Shared definitions for the ID-stage register file.
//   cmp_op_e : comparator mode encodings (codes 6 and 7 are reserved)
//   state_e  : clear-engine state
//   slice_lo : low bit of port <port> in a packed multi-port vector
package regfile_pkg;

    typedef enum logic [2:0] {
        CMP_EQ  = 3'd0,
        CMP_NE  = 3'd1,
        CMP_LTZ = 3'd2,
        CMP_GEZ = 3'd3,
        CMP_GTZ = 3'd4,
        CMP_LEZ = 3'd5
    } cmp_op_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_bypass_if.sv
// Bus bundle between decode/WB and the register file.
//   master : drives clr_req, we, waddr, wdata, raddr, cmp_op
//   slave  : the register file; returns rdata, cmp_true, ready, wr_err
interface regfile_bypass_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                       clr_req;
    logic                       we;
    logic [ADDR_W-1:0]          waddr;
    logic [DATA_W-1:0]          wdata;
    logic [NUM_RD*ADDR_W-1:0]   raddr;
    logic [NUM_RD*DATA_W-1:0]   rdata;
    logic [2:0]                 cmp_op;
    logic                       cmp_true;
    logic                       ready;
    logic                       wr_err;

    modport master (
        output clr_req, we, waddr, wdata, raddr, cmp_op,
        input  rdata, cmp_true, ready, wr_err
    );

    modport slave (
        input  clr_req, we, waddr, wdata, raddr, cmp_op,
        output rdata, cmp_true, ready, wr_err
    );
endinterface

// File: rtl/branch_cmp.sv
// Branch condition comparator, shared by ID and the EX branch unit.
//   a, b   : operands (a is the one tested against zero)
//   op     : cmp_op_e encoding; reserved codes give 0
//   result : condition outcome
module branch_cmp
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic              result
);

    logic a_neg_s;
    logic a_zero_s;

    // Zero tests treat a as two's complement, so its sign bit decides negativity.
    assign a_neg_s  = a[DATA_W-1];
    assign a_zero_s = (a == {DATA_W{1'b0}});

    // Mode select.
    always_comb begin
        result = 1'b0;
        case (op)
            CMP_EQ:  result = (a == b);
            CMP_NE:  result = (a != b);
            CMP_LTZ: result = a_neg_s;
            CMP_GEZ: result = !a_neg_s;
            CMP_GTZ: result = !a_neg_s && !a_zero_s;
            CMP_LEZ: result = a_neg_s || a_zero_s;
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/regfile_bypass.sv
// Parametrised ID-stage register file with WB write-through bypass,
// optional hardwired zero entry, branch comparator and a sequential
// clear engine (runs after rst or on clr_req).
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of regfile_bypass_if (write port, packed read
//              ports, comparator op/result, ready, wr_err)
module regfile_bypass
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic             clk,
    input  logic             rst,
    regfile_bypass_if.slave  bus
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_0   = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_0   = {DATA_W{1'b0}};

    state_e                   state_r, state_s;
    logic [ADDR_W-1:0]        clr_idx_r, clr_idx_s;
    logic                     wr_err_r, wr_err_s;
    logic [DATA_W-1:0]        mem_r [DEPTH];
    logic                     ready_s;
    logic                     wzero_s;
    logic                     mem_we_s;
    logic [ADDR_W-1:0]        ra_s;
    logic [NUM_RD*DATA_W-1:0] rdata_s;
    logic                     cmp_s;

    assign ready_s  = (state_r == ST_RUN);
    assign wzero_s  = (ZERO_REG != 0) && (bus.waddr == ADDR_0);
    // A write in the same cycle as an accepted clear request is dropped.
    assign mem_we_s = ready_s && bus.we && !bus.clr_req && !wzero_s;

    // Clear-engine next state, clear index and write-error flag.
    always_comb begin
        state_s   = state_r;
        clr_idx_s = clr_idx_r;
        wr_err_s  = 1'b0;
        case (state_r)
            ST_CLEAR: begin
                clr_idx_s = clr_idx_r + ADDR_W'(1);
                wr_err_s  = bus.we;
                if (clr_idx_r == LAST_IDX) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_CLEAR;
                end
            end
            ST_RUN: begin
                if (bus.clr_req) begin
                    state_s   = ST_CLEAR;
                    clr_idx_s = ADDR_0;
                    wr_err_s  = bus.we;
                end else begin
                    state_s   = ST_RUN;
                end
            end
            default: begin
                state_s   = ST_CLEAR;
                clr_idx_s = ADDR_0;
            end
        endcase
    end

    // Clear-engine state register; reset restarts any clear from entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_CLEAR;
            clr_idx_r <= ADDR_0;
            wr_err_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            clr_idx_r <= clr_idx_s;
            wr_err_r  <= wr_err_s;
        end
    end

    // Storage: zeroed one entry per cycle while clearing, WB write otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_r == ST_CLEAR) begin
                mem_r[clr_idx_r] <= DATA_0;
            end else if (mem_we_s) begin
                mem_r[bus.waddr] <= bus.wdata;
            end
        end
    end

    // Read ports: forced zero while clearing, then zero entry, bypass, array.
    always_comb begin
        rdata_s = {(NUM_RD*DATA_W){1'b0}};
        ra_s    = ADDR_0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra_s = bus.raddr[slice_lo(i, ADDR_W) +: ADDR_W];
            if (!ready_s) begin
                rdata_s[slice_lo(i, DATA_W) +: DATA_W] = DATA_0;
            end else if ((ZERO_REG != 0) && (ra_s == ADDR_0)) begin
                rdata_s[slice_lo(i, DATA_W) +: DATA_W] = DATA_0;
            end else if ((BYPASS != 0) && bus.we && (bus.waddr == ra_s) && !wzero_s) begin
                rdata_s[slice_lo(i, DATA_W) +: DATA_W] = bus.wdata;
            end else begin
                rdata_s[slice_lo(i, DATA_W) +: DATA_W] = mem_r[ra_s];
            end
        end
    end

    branch_cmp #(
        .DATA_W (DATA_W)
    ) u_cmp (
        .a      (rdata_s[DATA_W-1:0]),
        .b      (rdata_s[2*DATA_W-1:DATA_W]),
        .op     (bus.cmp_op),
        .result (cmp_s)
    );

    assign bus.rdata    = rdata_s;
    assign bus.cmp_true = cmp_s;
    assign bus.ready    = ready_s;
    assign bus.wr_err   = wr_err_r;

endmodule

// File: tb/tb_regfile_bypass.sv
module tb_regfile_bypass;

    logic clk = 1'b0;
    logic rst;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    logic [31:0] exp_q [$];
    logic [31:0] e;
    logic [31:0] model [32];

    always #5 clk = ~clk;

    regfile_bypass_if bus ();
    regfile_bypass_if bus_nb ();

    assign bus_nb.clr_req = bus.clr_req;
    assign bus_nb.we      = bus.we;
    assign bus_nb.waddr   = bus.waddr;
    assign bus_nb.wdata   = bus.wdata;
    assign bus_nb.raddr   = bus.raddr;
    assign bus_nb.cmp_op  = bus.cmp_op;

    regfile_bypass dut (.clk(clk), .rst(rst), .bus(bus));
    regfile_bypass #(.BYPASS(0)) dut_nb (.clk(clk), .rst(rst), .bus(bus_nb));

    wire [31:0] rd0    = bus.rdata[31:0];
    wire [31:0] rd1    = bus.rdata[63:32];
    wire [31:0] nb_rd0 = bus_nb.rdata[31:0];

    task automatic test_reset();
        int c;
        rst = 1'b1; bus.clr_req = 1'b0; bus.we = 1'b0; bus.waddr = 5'd0;
        bus.wdata = 32'h0; bus.raddr = {5'd7, 5'd3}; bus.cmp_op = 3'd5;
        @(posedge clk); @(negedge clk);
        total_cnt++; if (bus.ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", bus.ready); else pass_cnt++;
        total_cnt++; if (bus.wr_err !== 1'b0) $display("FAIL reset_wr_err: got %b want 0", bus.wr_err); else pass_cnt++;
        total_cnt++; if (bus.rdata !== 64'h0) $display("FAIL reset_rdata: got %h want 0", bus.rdata); else pass_cnt++;
        total_cnt++; if (bus.cmp_true !== 1'b1) $display("FAIL reset_cmp_lez: got %b want 1", bus.cmp_true); else pass_cnt++;
        rst = 1'b0; bus.cmp_op = 3'd0;
        c = 0;
        while (c < 100) begin
            @(negedge clk); c++;
            if (bus.ready) break;
            if (c == 5) begin
                total_cnt++; if (bus.rdata !== 64'h0) $display("FAIL clear_forced_zero: got %h want 0", bus.rdata); else pass_cnt++;
                total_cnt++; if (bus.cmp_true !== 1'b1) $display("FAIL clear_cmp_eq: got %b want 1", bus.cmp_true); else pass_cnt++;
            end
        end
        total_cnt++; if (c !== 32) $display("FAIL reset_clear_len: got %0d want 32", c); else pass_cnt++;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        for (int a = 0; a < 32; a++) begin
            bus.raddr = {5'(31 - a), 5'(a)};
            exp_q.push_back(model[a]); exp_q.push_back(model[31 - a]);
            #1;
            e = exp_q.pop_front();
            total_cnt++; if (rd0 !== e) $display("FAIL sweep_rd0[%0d]: got %h want %h", a, rd0, e); else pass_cnt++;
            e = exp_q.pop_front();
            total_cnt++; if (rd1 !== e) $display("FAIL sweep_rd1[%0d]: got %h want %h", 31 - a, rd1, e); else pass_cnt++;
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        bus.we = 1'b1; bus.waddr = 5'd8; bus.wdata = 32'h1234ABCD; bus.raddr = {5'd8, 5'd8};
        exp_q.push_back(32'h1234ABCD); exp_q.push_back(32'h1234ABCD); exp_q.push_back(model[8]);
        #1;
        e = exp_q.pop_front();
        total_cnt++; if (rd0 !== e) $display("FAIL bypass_rd0: got %h want %h", rd0, e); else pass_cnt++;
        e = exp_q.pop_front();
        total_cnt++; if (rd1 !== e) $display("FAIL bypass_dup_rd1: got %h want %h", rd1, e); else pass_cnt++;
        e = exp_q.pop_front();
        total_cnt++; if (nb_rd0 !== e) $display("FAIL nobypass_old: got %h want %h", nb_rd0, e); else pass_cnt++;
        model[8] = 32'h1234ABCD;
        @(negedge clk);
        bus.we = 1'b0;
        exp_q.push_back(model[8]); exp_q.push_back(model[8]);
        #1;
        e = exp_q.pop_front();
        total_cnt++; if (rd0 !== e) $display("FAIL stored_rd0: got %h want %h", rd0, e); else pass_cnt++;
        e = exp_q.pop_front();
        total_cnt++; if (nb_rd0 !== e) $display("FAIL nobypass_new: got %h want %h", nb_rd0, e); else pass_cnt++;
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hFFFFFFFF; bus.raddr = {5'd8, 5'd0};
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front();
        total_cnt++; if (rd0 !== e) $display("FAIL zero_write_cycle: got %h want %h", rd0, e); else pass_cnt++;
        e = exp_q.pop_front();
        total_cnt++; if (nb_rd0 !== e) $display("FAIL zero_write_cycle_nb: got %h want %h", nb_rd0, e); else pass_cnt++;
        @(negedge clk);
        bus.we = 1'b0;
        total_cnt++; if (bus.wr_err !== 1'b0) $display("FAIL zero_wr_err: got %b want 0", bus.wr_err); else pass_cnt++;
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front();
        total_cnt++; if (rd0 !== e) $display("FAIL zero_after: got %h want %h", rd0, e); else pass_cnt++;
    endtask

    task automatic test_cmp();
        logic [7:0] want_bits;
        @(negedge clk);
        bus.we = 1'b1; bus.waddr = 5'd8; bus.wdata = 32'hFFFFFFFE; bus.raddr = {5'd9, 5'd8}; bus.cmp_op = 3'd0;
        #1;
        total_cnt++; if (bus.cmp_true !== 1'b0) $display("FAIL cmp_byp_eq0: got %b want 0", bus.cmp_true); else pass_cnt++;
        @(negedge clk);
        bus.waddr = 5'd9; bus.wdata = 32'hFFFFFFFE;
        #1;
        total_cnt++; if (bus.cmp_true !== 1'b1) $display("FAIL cmp_byp_eq1: got %b want 1", bus.cmp_true); else pass_cnt++;
        @(negedge clk);
        bus.wdata = 32'h00000003;
        exp_q.push_back(32'h00000003);
        #1;
        e = exp_q.pop_front();
        total_cnt++; if (rd1 !== e) $display("FAIL b2b_rd1: got %h want %h", rd1, e); else pass_cnt++;
        total_cnt++; if (bus.cmp_true !== 1'b0) $display("FAIL cmp_byp_eq2: got %b want 0", bus.cmp_true); else pass_cnt++;
        model[8] = 32'hFFFFFFFE; model[9] = 32'h00000003;
        @(negedge clk);
        bus.we = 1'b0;
        want_bits = 8'b0010_0110;
        for (int op = 0; op < 8; op++) begin
            bus.cmp_op = 3'(op);
            exp_q.push_back({31'd0, want_bits[op]});
            #1;
            e = exp_q.pop_front();
            total_cnt++; if (bus.cmp_true !== e[0]) $display("FAIL cmp_op%0d: got %b want %b", op, bus.cmp_true, e[0]); else pass_cnt++;
        end
        bus.raddr = {5'd8, 5'd9};
        bus.cmp_op = 3'd4; #1;
        total_cnt++; if (bus.cmp_true !== 1'b1) $display("FAIL cmp_gtz_pos: got %b want 1", bus.cmp_true); else pass_cnt++;
        bus.cmp_op = 3'd5; #1;
        total_cnt++; if (bus.cmp_true !== 1'b0) $display("FAIL cmp_lez_pos: got %b want 0", bus.cmp_true); else pass_cnt++;
        bus.raddr = {5'd8, 5'd0};
        bus.cmp_op = 3'd4; #1;
        total_cnt++; if (bus.cmp_true !== 1'b0) $display("FAIL cmp_gtz_zero: got %b want 0", bus.cmp_true); else pass_cnt++;
        bus.cmp_op = 3'd3; #1;
        total_cnt++; if (bus.cmp_true !== 1'b1) $display("FAIL cmp_gez_zero: got %b want 1", bus.cmp_true); else pass_cnt++;
        bus.cmp_op = 3'd0;
    endtask

    task automatic test_clear_req();
        int c;
        @(negedge clk);
        bus.we = 1'b1; bus.waddr = 5'd4; bus.wdata = 32'h55AA0004; bus.raddr = {5'd0, 5'd4};
        @(negedge clk);
        bus.clr_req = 1'b1; bus.wdata = 32'h0000DEAD; bus.raddr = {5'd0, 5'd9};
        c = 0;
        while (c < 100) begin
            @(negedge clk); c++;
            if (c == 1) begin
                bus.clr_req = 1'b0; bus.we = 1'b0;
                total_cnt++; if (bus.wr_err !== 1'b1) $display("FAIL clr_wr_err_pulse: got %b want 1", bus.wr_err); else pass_cnt++;
                total_cnt++; if (bus.ready !== 1'b0) $display("FAIL clr_ready_low: got %b want 0", bus.ready); else pass_cnt++;
                #1;
                total_cnt++; if (rd0 !== 32'h0) $display("FAIL clr_forced_zero: got %h want 0", rd0); else pass_cnt++;
            end
            if (c == 2) begin
                total_cnt++; if (bus.wr_err !== 1'b0) $display("FAIL clr_wr_err_once: got %b want 0", bus.wr_err); else pass_cnt++;
            end
            if (bus.ready) break;
        end
        total_cnt++; if (c !== 33) $display("FAIL clr_req_len: got %0d want 33", c); else pass_cnt++;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        bus.raddr = {5'd9, 5'd4};
        exp_q.push_back(model[4]); exp_q.push_back(model[9]);
        #1;
        e = exp_q.pop_front();
        total_cnt++; if (rd0 !== e) $display("FAIL clr_r4: got %h want %h", rd0, e); else pass_cnt++;
        e = exp_q.pop_front();
        total_cnt++; if (rd1 !== e) $display("FAIL clr_r9: got %h want %h", rd1, e); else pass_cnt++;
    endtask

    task automatic test_reset_mid_clear();
        int c;
        @(negedge clk);
        bus.clr_req = 1'b1; bus.we = 1'b0; bus.raddr = {5'd5, 5'd3};
        for (c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) begin
                total_cnt++; if (bus.wr_err !== 1'b0) $display("FAIL mid_wr_err_c1: got %b want 0", bus.wr_err); else pass_cnt++;
            end else begin
                total_cnt++; if (bus.wr_err !== 1'b1) $display("FAIL mid_wr_err_c%0d: got %b want 1", c, bus.wr_err); else pass_cnt++;
            end
            bus.clr_req = 1'b0; bus.we = 1'b1; bus.waddr = 5'(c); bus.wdata = 32'hA5A50000 | 32'(c);
        end
        rst = 1'b1;
        @(negedge clk);
        total_cnt++; if (bus.wr_err !== 1'b0) $display("FAIL mid_rst_wr_err: got %b want 0", bus.wr_err); else pass_cnt++;
        total_cnt++; if (bus.ready !== 1'b0) $display("FAIL mid_rst_ready: got %b want 0", bus.ready); else pass_cnt++;
        rst = 1'b0;
        c = 0;
        while (c < 100) begin
            @(negedge clk); c++;
            total_cnt++; if (bus.wr_err !== 1'b1) $display("FAIL mid_clear_wr_err_c%0d: got %b want 1", c, bus.wr_err); else pass_cnt++;
            if (bus.ready) break;
            bus.waddr = 5'(c + 3);
        end
        total_cnt++; if (c !== 32) $display("FAIL mid_restart_len: got %0d want 32", c); else pass_cnt++;
        bus.we = 1'b0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front();
        total_cnt++; if (rd0 !== e) $display("FAIL mid_drop_r3: got %h want %h", rd0, e); else pass_cnt++;
        e = exp_q.pop_front();
        total_cnt++; if (rd1 !== e) $display("FAIL mid_drop_r5: got %h want %h", rd1, e); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (bus.wr_err !== 1'b0) $display("FAIL mid_wr_err_idle: got %b want 0", bus.wr_err); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_reg();
        test_cmp();
        test_clear_req();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/regfile_bypass.md
Name: regfile_bypass

Overview:
- Parametrised ID-stage register file; successor to the fixed 32x32, 2-read-port file.
- Adds configurable width, depth and read-port count, plus WB-to-ID write-through bypass.
- Adds a hardwired zero register, a multi-mode branch comparator, and a sequential clear engine that runs on reset or on request.
- Sits in ID, between instruction decode (read addresses) and the WB stage (write port).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of read ports (>=2; ports 0/1 feed comparator)
ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset
clr_req  in  1  request a full clear (sampled only when ready=1)
we  in  1  write enable from WB
waddr  in  ADDR_W  write address from WB
wdata  in  DATA_W  write data from WB
raddr  in  NUM_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
rdata  out  NUM_RD*DATA_W  packed read data, same packing
cmp_op  in  3  comparator mode (package encoding)
cmp_true  out  1  comparator result on rdata port 0 vs port 1
ready  out  1  1 = file usable; 0 = clear in progress
wr_err  out  1  one-cycle pulse: write attempted while ready=0

Behaviour:
- States: CLEAR, RUN.
- Reset:
  - rst=1 at posedge -> state=CLEAR, clr_idx=0, ready=0, wr_err=0.
  - rst has priority over everything, including mid-clear; a clear in progress restarts at index 0.
- CLEAR:
  - Each cycle writes 0 to entry clr_idx, then increments it.
  - After entry DEPTH-1 is written -> RUN; ready=1 from the next cycle.
  - A clear takes exactly DEPTH cycles after rst deasserts.
  - clr_req is ignored during CLEAR.
  - All rdata forced to 0 while ready=0.
- RUN, clear request: clr_req=1 at posedge -> CLEAR, clr_idx=0. The simultaneous write is dropped and flagged via wr_err.
- RUN, writes:
  - we=1 -> entry[waddr] <= wdata at posedge.
  - If ZERO_REG and waddr==0, the write is discarded silently, with no wr_err.
- wr_err: registered; asserts the cycle after any posedge where we=1 and (state==CLEAR or clr_req accepted). Otherwise 0.
- Reads: combinational, zero latency.
  - rdata[i] = 0 if ZERO_REG and raddr[i]==0.
  - Else wdata if BYPASS && we && ready && waddr==raddr[i] && !(ZERO_REG && waddr==0).
  - Else entry[raddr[i]].
- BYPASS=0: read returns the old value in the write cycle and the new value from the next cycle.
- Duplicate read addresses are legal and return identical data.
- Comparator: combinational on post-bypass rdata port 0 (a) and port 1 (b), signed for LTZ/GEZ/GTZ/LEZ. Ops:
  - EQ a==b
  - NE a!=b
  - LTZ a<0
  - GEZ a>=0
  - GTZ a>0
  - LEZ a<=0
  - Reserved codes -> 0
  - While ready=0, result follows forced-zero data (EQ=1).
- Output values at reset: ready=0, wr_err=0, rdata=0, cmp_true=(cmp_op in {EQ,GEZ,LEZ}).

Decomposition:
- Package regfile_pkg:
  - cmp_op encodings: EQ=0, NE=1, LTZ=2, GEZ=3, GTZ=4, LEZ=5.
  - FSM state enum: CLEAR, RUN.
  - Function packing/unpacking port slices.
- One sub-module, branch_cmp (DATA_W param; a, b, op -> result), reusable by the EX-stage branch unit.
- Storage array, clear FSM and bypass muxes stay in regfile_bypass.

Test Plan:
- Reset clear: rst 1 cycle, DATA_W=32, ADDR_W=5 -> ready=0 for 32 cycles then 1. All raddr 0..31 read 0x00000000. cmp_op=EQ gives cmp_true=1.
- Write/read: we=1, waddr=8, wdata=0x1234ABCD, raddr0=8 -> rdata0=0x1234ABCD in the same cycle (BYPASS=1). With BYPASS=0: old value 0 that cycle, 0x1234ABCD the next.
- Zero register: write 0xFFFFFFFF to waddr=0, raddr0=0 -> rdata0=0 in the write cycle and after. wr_err=0.
- Comparator: r8=0xFFFFFFFE, r9=0x00000003, raddr0=8, raddr1=9:
  - EQ->0, NE->1, LTZ->1, GEZ->0, GTZ->0, LEZ->1.
  - Code 7 -> 0.
- Clear request: after data written, clr_req=1 with we=1, waddr=4 -> wr_err=1 the next cycle only, ready=0 for 32 cycles, then r4 reads 0.
- Reset mid-clear: assert rst at clear cycle 10 -> clear restarts, ready rises exactly 32 cycles after rst deasserts. Writes in between are dropped, each pulsing wr_err.
